// File: rtl/jpegls_neighbor_context.sv
// JPEG-LS decoder causal-template generator.
// Emits the a/b/c/d neighbors for the next pixel position, then waits for
// that pixel's reconstructed value before advancing. Holds one line buffer
// of the previous row and applies the T.87 edge rules at row/frame borders.
// Optional feature macro: LOCAL_GRADIENT_EN adds the registered local
// gradients d1_o = d-b, d2_o = b-c, d3_o = c-a.
module jpegls_neighbor_context #(
  parameter int unsigned pixel_length = 8,
  parameter int unsigned image_width  = 64,
  parameter int unsigned image_height = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [pixel_length-1:0]   rec_pixel_i,
  input  logic                      rec_valid_i,
  output logic                      rec_ready_o,
  output logic [pixel_length-1:0]   a_o,
  output logic [pixel_length-1:0]   b_o,
  output logic [pixel_length-1:0]   c_o,
  output logic [pixel_length-1:0]   d_o,
  output logic                      ctx_valid_o,
  input  logic                      ctx_ready_i,
  output logic                      first_col_o,
  output logic                      last_col_o,
  output logic                      first_row_o,
`ifdef LOCAL_GRADIENT_EN
  output logic signed [pixel_length:0] d1_o,
  output logic signed [pixel_length:0] d2_o,
  output logic signed [pixel_length:0] d3_o,
`endif
  output logic                      frame_done_o
);

  localparam int unsigned PW = pixel_length;
  localparam int unsigned CW = (image_width  > 1) ? $clog2(image_width)  : 1;
  localparam int unsigned RW = (image_height > 1) ? $clog2(image_height) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(image_width - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(image_height - 1);

  typedef enum logic {ST_EMIT = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t          state_q;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [PW-1:0]   cstart_q, cstart_d;
  logic [PW-1:0]   linebuf_q [image_width];
  logic [PW-1:0]   a_q, b_q, c_q, d_q;
  logic [PW-1:0]   a_d, b_d, c_d, d_d;
  logic            ctx_valid_q, rec_ready_q, frame_done_q;
  logic            first_col_q, last_col_q, first_row_q;
  logic            wb_fire, last_px;
  logic [CW-1:0]   d_idx;
  logic [PW-1:0]   b_fwd, d_fwd, c_above;
`ifdef LOCAL_GRADIENT_EN
  logic signed [PW:0] d1_q, d2_q, d3_q;
  logic signed [PW:0] d1_d, d2_d, d3_d;
`endif

  // Next position and the template it sees once the current write-back lands
  always_comb begin
    wb_fire  = (state_q == ST_WAIT) && rec_ready_q && rec_valid_i;
    last_px  = (col_q == COL_LAST) && (row_q == ROW_LAST);
    col_d    = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
    row_d    = row_q;
    if (col_q == COL_LAST) row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
    // cstart holds the pixel two rows up at column 0; zero while on row 1
    cstart_d = cstart_q;
    if (col_q == '0) cstart_d = (row_q == '0) ? '0 : linebuf_q[0];
    c_above  = linebuf_q[col_q];
    // Forward the pixel being written so reads never see a stale entry
    d_idx    = (col_d == COL_LAST) ? col_d : col_d + CW'(1);
    b_fwd    = (col_d == col_q) ? rec_pixel_i : linebuf_q[col_d];
    d_fwd    = (d_idx == col_q) ? rec_pixel_i : linebuf_q[d_idx];
    a_d = '0;
    b_d = '0;
    c_d = '0;
    d_d = '0;
    if (row_d == '0) begin
      a_d = (col_d == '0) ? '0 : rec_pixel_i;
    end else begin
      b_d = b_fwd;
      d_d = (col_d == COL_LAST) ? b_fwd : d_fwd;
      if (col_d == '0) begin
        a_d = b_fwd;
        c_d = cstart_d;
      end else begin
        a_d = rec_pixel_i;
        c_d = c_above;
      end
    end
`ifdef LOCAL_GRADIENT_EN
    d1_d = $signed({1'b0, d_d}) - $signed({1'b0, b_d});
    d2_d = $signed({1'b0, b_d}) - $signed({1'b0, c_d});
    d3_d = $signed({1'b0, c_d}) - $signed({1'b0, a_d});
`endif
  end

  // Line buffer write; contents are masked on row 0 so no reset is needed
  always_ff @(posedge clk) begin
    if (!reset && wb_fire) linebuf_q[col_q] <= rec_pixel_i;
  end

  // Emit/wait handshake FSM with counters and registered template
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_EMIT;
      col_q        <= '0;
      row_q        <= '0;
      cstart_q     <= '0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      d_q          <= '0;
      ctx_valid_q  <= 1'b0;
      rec_ready_q  <= 1'b0;
      frame_done_q <= 1'b0;
      first_col_q  <= 1'b0;
      last_col_q   <= 1'b0;
      first_row_q  <= 1'b0;
`ifdef LOCAL_GRADIENT_EN
      d1_q <= '0;
      d2_q <= '0;
      d3_q <= '0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        ST_EMIT: begin
          if (!ctx_valid_q) begin
            // First template after reset: origin of the frame, all zero
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            first_col_q <= (col_q == '0);
            last_col_q  <= (col_q == COL_LAST);
            first_row_q <= (row_q == '0);
            ctx_valid_q <= 1'b1;
`ifdef LOCAL_GRADIENT_EN
            d1_q <= '0;
            d2_q <= '0;
            d3_q <= '0;
`endif
          end else if (ctx_ready_i) begin
            ctx_valid_q <= 1'b0;
            rec_ready_q <= 1'b1;
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wb_fire) begin
            col_q        <= col_d;
            row_q        <= row_d;
            cstart_q     <= cstart_d;
            a_q          <= a_d;
            b_q          <= b_d;
            c_q          <= c_d;
            d_q          <= d_d;
            first_col_q  <= (col_d == '0);
            last_col_q   <= (col_d == COL_LAST);
            first_row_q  <= (row_d == '0);
            frame_done_q <= last_px;
            rec_ready_q  <= 1'b0;
            ctx_valid_q  <= 1'b1;
            state_q      <= ST_EMIT;
`ifdef LOCAL_GRADIENT_EN
            d1_q <= d1_d;
            d2_q <= d2_d;
            d3_q <= d3_d;
`endif
          end
        end
        default: state_q <= ST_EMIT;
      endcase
    end
  end

  assign a_o          = a_q;
  assign b_o          = b_q;
  assign c_o          = c_q;
  assign d_o          = d_q;
  assign ctx_valid_o  = ctx_valid_q;
  assign rec_ready_o  = rec_ready_q;
  assign first_col_o  = first_col_q;
  assign last_col_o   = last_col_q;
  assign first_row_o  = first_row_q;
  assign frame_done_o = frame_done_q;
`ifdef LOCAL_GRADIENT_EN
  assign d1_o = d1_q;
  assign d2_o = d2_q;
  assign d3_o = d3_q;
`endif

endmodule

// File: tb/tb_jpegls_neighbor_context.sv
// Directed bench for jpegls_neighbor_context on a 4x3 image, 8-bit pixels.
// Write-back value for (row, col) is 10*row + col + 1.
module tb_jpegls_neighbor_context;

  localparam int unsigned W = 4;
  localparam int unsigned H = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rec_pixel;
  logic       rec_valid;
  logic       rec_ready;
  logic [7:0] a, b, c, d;
  logic       ctx_valid;
  logic       ctx_ready;
  logic       first_col, last_col, first_row;
  logic       frame_done;
`ifdef LOCAL_GRADIENT_EN
  logic signed [8:0] g1, g2, g3;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  // Hand-computed templates {a,b,c,d} for pixel index row*4+col
  logic [31:0] exp_tpl [12];

  jpegls_neighbor_context #(
    .pixel_length(8), .image_width(W), .image_height(H)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rec_pixel_i  (rec_pixel),
    .rec_valid_i  (rec_valid),
    .rec_ready_o  (rec_ready),
    .a_o          (a),
    .b_o          (b),
    .c_o          (c),
    .d_o          (d),
    .ctx_valid_o  (ctx_valid),
    .ctx_ready_i  (ctx_ready),
    .first_col_o  (first_col),
    .last_col_o   (last_col),
    .first_row_o  (first_row),
`ifdef LOCAL_GRADIENT_EN
    .d1_o         (g1),
    .d2_o         (g2),
    .d3_o         (g3),
`endif
    .frame_done_o (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
  endtask

  task automatic check_tpl(input int i);
    logic [31:0] t;
    int r, cc;
    t  = exp_tpl[i];
    r  = i / 4;
    cc = i % 4;
    chk($sformatf("a[%0d]", i), 32'(a), 32'(t[31:24]));
    chk($sformatf("b[%0d]", i), 32'(b), 32'(t[23:16]));
    chk($sformatf("c[%0d]", i), 32'(c), 32'(t[15:8]));
    chk($sformatf("d[%0d]", i), 32'(d), 32'(t[7:0]));
    chk($sformatf("first_col[%0d]", i), 32'(first_col), 32'(cc == 0));
    chk($sformatf("last_col[%0d]", i),  32'(last_col),  32'(cc == 3));
    chk($sformatf("first_row[%0d]", i), 32'(first_row), 32'(r == 0));
`ifdef LOCAL_GRADIENT_EN
    chk($sformatf("D1[%0d]", i), 32'(int'(g1)), 32'(int'(t[7:0])   - int'(t[23:16])));
    chk($sformatf("D2[%0d]", i), 32'(int'(g2)), 32'(int'(t[23:16]) - int'(t[15:8])));
    chk($sformatf("D3[%0d]", i), 32'(int'(g3)), 32'(int'(t[15:8])  - int'(t[31:24])));
`endif
  endtask

  task automatic wait_ctx(input string tag);
    int n;
    n = 0;
    while (!ctx_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ctx_valid_timeout"}, 32'(ctx_valid), 32'd1);
  endtask

  // One pixel: check template, optional stalls, then write back 10*r+c+1
  task automatic do_pixel(input int i, input bit bp_emit, input bit bp_wait);
    wait_ctx($sformatf("px%0d", i));
    check_tpl(i);
    if (bp_emit) begin
      rec_valid = 1'b1;
      rec_pixel = 8'hEE;
      repeat (5) begin
        @(negedge clk);
        chk("emit_hold_ctx_valid", 32'(ctx_valid), 32'd1);
        chk("emit_hold_rec_ready", 32'(rec_ready), 32'd0);
        check_tpl(i);
      end
      rec_valid = 1'b0;
    end
    ctx_ready = 1'b1;
    @(negedge clk);
    ctx_ready = 1'b0;
    chk("after_ctx_hs_ctx_valid", 32'(ctx_valid), 32'd0);
    chk("after_ctx_hs_rec_ready", 32'(rec_ready), 32'd1);
    if (bp_wait) begin
      repeat (5) begin
        @(negedge clk);
        chk("wait_hold_ctx_valid", 32'(ctx_valid), 32'd0);
        chk("wait_hold_rec_ready", 32'(rec_ready), 32'd1);
      end
    end
    rec_pixel = 8'(10 * (i / 4) + (i % 4) + 1);
    rec_valid = 1'b1;
    @(negedge clk);
    rec_valid = 1'b0;
    chk("after_wb_ctx_valid", 32'(ctx_valid), 32'd1);
    chk("after_wb_rec_ready", 32'(rec_ready), 32'd0);
    chk($sformatf("frame_done[%0d]", i), 32'(frame_done), 32'(i == 11));
  endtask

  initial begin
    exp_tpl = '{32'h00000000, 32'h01000000, 32'h02000000, 32'h03000000,
                32'h01010002, 32'h0B020103, 32'h0C030204, 32'h0D040304,
                32'h0B0B010C, 32'h150C0B0D, 32'h160D0C0E, 32'h170E0D0E};
    reset     = 1'b1;
    rec_pixel = '0;
    rec_valid = 1'b0;
    ctx_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Outputs while reset is held
    chk("rst_ctx_valid",  32'(ctx_valid),  32'd0);
    chk("rst_rec_ready",  32'(rec_ready),  32'd0);
    chk("rst_a",          32'(a),          32'd0);
    chk("rst_first_col",  32'(first_col),  32'd0);
    chk("rst_first_row",  32'(first_row),  32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ctx_valid", 32'(ctx_valid), 32'd1);

    // Frame 1 with ctx backpressure at px2 and write-back stall at px5
    for (int i = 0; i < 12; i++) do_pixel(i, i == 2, i == 5);
`ifdef LOCAL_GRADIENT_EN
    chk("frame_end_D1_zero", 32'(int'(g1)), 32'd0);
`endif
    @(negedge clk);
    chk("frame_done_one_cycle", 32'(frame_done), 32'd0);
    chk("frame2_first_row",     32'(first_row),  32'd1);

    // Frame 2 repeats frame 1, with an explicit gradient spot check
    for (int i = 0; i < 12; i++) begin
`ifdef LOCAL_GRADIENT_EN
      if (i == 5) begin
        wait_ctx("grad");
        chk("D1_r1c1", 32'(int'(g1)), 32'd1);
        chk("D2_r1c1", 32'(int'(g2)), 32'd1);
        chk("D3_r1c1", 32'(int'(g3)), -32'sd10);
      end
`endif
      do_pixel(i, 1'b0, 1'b0);
    end

    // Frame 3: reset at row1/col2 while waiting for the write-back
    for (int i = 0; i < 6; i++) do_pixel(i, 1'b0, 1'b0);
    wait_ctx("px6_pre_rst");
    check_tpl(6);
    ctx_ready = 1'b1;
    @(negedge clk);
    ctx_ready = 1'b0;
    chk("pre_rst_rec_ready", 32'(rec_ready), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_ctx_valid", 32'(ctx_valid), 32'd0);
    chk("mid_rst_rec_ready", 32'(rec_ready), 32'd0);
    chk("mid_rst_d",         32'(d),         32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_post_rst_ctx_valid", 32'(ctx_valid), 32'd1);
    for (int i = 0; i < 4; i++) do_pixel(i, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
